cpu_control_fsm: RTL and testbench

//  Multi-cycle control FSM for the 16-bit CPU; parametrised successor to the current control unit.

---
 rtl/cpu_isa_pkg.sv | 90 +++++++++
 rtl/cpu_control_fsm_if.sv | 43 ++++
 rtl/cpu_control_fsm.sv | 159 +++++++++++++++
 tb/tb_cpu_control_fsm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the multi-cycle CPU control path: opcodes, ALU
// select codes, controller states and instruction-field helpers.
package cpu_isa_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5,
    OP_AND   = 4'h6,
    OP_OR    = 4'h7,
    OP_XOR   = 4'h8,
    OP_SHL   = 4'h9,
    OP_SHR   = 4'hA,
    OP_JMP   = 4'hB,
    OP_BEQ   = 4'hC,
    OP_BNE   = 4'hD,
    OP_ILL_E = 4'hE,
    OP_ILL_F = 4'hF
  } opcode_e;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd7;
  localparam logic [3:0] ALU_SHR  = 4'd8;

  // Load wait counter is sized for the largest supported latency.
  localparam int CNT_W = $clog2(4);

  typedef enum logic [4:0] {
    S_INIT   = 5'd0,
    S_FETCH  = 5'd1,
    S_DECODE = 5'd2,
    S_EXEC   = 5'd3,
    S_LOAD_A = 5'd4,
    S_LOAD_W = 5'd5,
    S_LOAD_B = 5'd6,
    S_STORE  = 5'd7,
    S_JMP    = 5'd8,
    S_BR_CMP = 5'd9,
    S_BR_RES = 5'd10,
    S_NOOP   = 5'd11,
    S_HALT   = 5'd12,
    S_TRAP   = 5'd13
  } state_e;

  function automatic opcode_e ir_op(input logic [15:0] ir);
    return opcode_e'(ir[15:12]);
  endfunction

  function automatic logic [3:0] ir_ra(input logic [15:0] ir);
    return ir[11:8];
  endfunction

  function automatic logic [3:0] ir_rb(input logic [15:0] ir);
    return ir[7:4];
  endfunction

  function automatic logic [3:0] ir_rw(input logic [15:0] ir);
    return ir[3:0];
  endfunction

  function automatic logic [7:0] ir_ld_addr(input logic [15:0] ir);
    return ir[11:4];
  endfunction

  function automatic logic [7:0] ir_st_addr(input logic [15:0] ir);
    return ir[7:0];
  endfunction

  function automatic logic [3:0] alu_code(input opcode_e op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_SHL:  return ALU_SHL;
      OP_SHR:  return ALU_SHR;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Controller <-> datapath bundle. master = control FSM, slave = datapath side.
interface cpu_control_fsm_if #(
  parameter int PC_W      = 8,
  parameter int ALU_SEL_W = 4
);
  // No valid/ready pairs here: IR and ALU_Z are level inputs sampled in the
  // states that use them; Run is a level request honoured only while halted.
  logic [15:0]          IR;
  logic                 ALU_Z;
  logic                 Run;
  logic                 PC_CLR;
  logic                 PC_IC;
  logic                 PC_LD;
  logic                 PC_REL;
  logic [PC_W-1:0]      PC_D;
  logic [3:0]           PC_OFF;
  logic                 IR_LD;
  logic [7:0]           D_ADDR;
  logic                 D_WR;
  logic                 RF_S;
  logic                 RF_W_EN;
  logic [3:0]           RF_A_ADDR;
  logic [3:0]           RF_B_ADDR;
  logic [3:0]           RF_W_ADDR;
  logic [ALU_SEL_W-1:0] ALU_S;
  logic                 Halted;
  logic                 Illegal;
  logic [4:0]           state;

  modport master (
    input  IR, ALU_Z, Run,
    output PC_CLR, PC_IC, PC_LD, PC_REL, PC_D, PC_OFF, IR_LD, D_ADDR, D_WR,
           RF_S, RF_W_EN, RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S, Halted,
           Illegal, state
  );

  modport slave (
    output IR, ALU_Z, Run,
    input  PC_CLR, PC_IC, PC_LD, PC_REL, PC_D, PC_OFF, IR_LD, D_ADDR, D_WR,
           RF_S, RF_W_EN, RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S, Halted,
           Illegal, state
  );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control FSM for the 16-bit CPU. Each edge registers the outputs
// of the current state, so outputs appear one cycle after the state is entered.
module cpu_control_fsm
  import cpu_isa_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int LOAD_LAT  = 1,
  parameter int ALU_SEL_W = 4,
  parameter int BR_EN     = 1
) (
  input logic               Clock,
  input logic               Reset,
  cpu_control_fsm_if.master bus
);

  localparam logic [CNT_W-1:0] WAIT_INIT =
    (LOAD_LAT > 1) ? CNT_W'(LOAD_LAT - 2) : '0;

  state_e               state_q;
  logic [CNT_W-1:0]     wait_q;
  logic                 pc_clr_q, pc_ic_q, pc_ld_q, pc_rel_q;
  logic [PC_W-1:0]      pc_d_q;
  logic [3:0]           pc_off_q;
  logic                 ir_ld_q;
  logic [7:0]           d_addr_q;
  logic                 d_wr_q, rf_s_q, rf_w_en_q;
  logic [3:0]           rf_a_q, rf_b_q, rf_w_q;
  logic [ALU_SEL_W-1:0] alu_s_q;
  logic                 halted_q, illegal_q;

  always_ff @(posedge Clock) begin
    pc_clr_q  <= 1'b0;
    pc_ic_q   <= 1'b0;
    pc_ld_q   <= 1'b0;
    pc_rel_q  <= 1'b0;
    pc_d_q    <= '0;
    pc_off_q  <= '0;
    ir_ld_q   <= 1'b0;
    d_addr_q  <= '0;
    d_wr_q    <= 1'b0;
    rf_s_q    <= 1'b0;
    rf_w_en_q <= 1'b0;
    rf_a_q    <= '0;
    rf_b_q    <= '0;
    rf_w_q    <= '0;
    alu_s_q   <= '0;
    halted_q  <= 1'b0;
    illegal_q <= 1'b0;
    if (!Reset) begin
      state_q <= S_INIT;
      wait_q  <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          pc_clr_q <= 1'b1;
          state_q  <= S_FETCH;
        end
        S_FETCH: begin
          ir_ld_q <= 1'b1;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          pc_ic_q <= 1'b1;
          case (ir_op(bus.IR))
            OP_NOOP:  state_q <= S_NOOP;
            OP_STORE: state_q <= S_STORE;
            OP_LOAD:  state_q <= S_LOAD_A;
            OP_HALT:  state_q <= S_HALT;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR:
              state_q <= S_EXEC;
            OP_JMP:   state_q <= (BR_EN != 0) ? S_JMP : S_TRAP;
            OP_BEQ, OP_BNE:
              state_q <= (BR_EN != 0) ? S_BR_CMP : S_TRAP;
            default:  state_q <= S_TRAP;
          endcase
        end
        S_EXEC: begin
          rf_a_q    <= ir_ra(bus.IR);
          rf_b_q    <= ir_rb(bus.IR);
          rf_w_q    <= ir_rw(bus.IR);
          rf_w_en_q <= 1'b1;
          alu_s_q   <= ALU_SEL_W'(alu_code(ir_op(bus.IR)));
          state_q   <= S_FETCH;
        end
        S_LOAD_A, S_LOAD_W, S_LOAD_B: begin
          // Address and mux select stay stable for the whole memory access.
          d_addr_q <= ir_ld_addr(bus.IR);
          rf_s_q   <= 1'b1;
          rf_w_q   <= ir_rw(bus.IR);
          if (state_q == S_LOAD_A) begin
            wait_q  <= WAIT_INIT;
            state_q <= (LOAD_LAT > 1) ? S_LOAD_W : S_LOAD_B;
          end else if (state_q == S_LOAD_W) begin
            if (wait_q == '0) state_q <= S_LOAD_B;
            else              wait_q  <= wait_q - 1'b1;
          end else begin
            rf_w_en_q <= 1'b1;
            state_q   <= S_FETCH;
          end
        end
        S_STORE: begin
          d_addr_q <= ir_st_addr(bus.IR);
          rf_a_q   <= ir_ra(bus.IR);
          d_wr_q   <= 1'b1;
          state_q  <= S_FETCH;
        end
        S_JMP: begin
          pc_ld_q <= 1'b1;
          pc_d_q  <= bus.IR[PC_W-1:0];
          state_q <= S_FETCH;
        end
        S_BR_CMP: begin
          rf_a_q  <= ir_ra(bus.IR);
          rf_b_q  <= ir_rb(bus.IR);
          alu_s_q <= ALU_SEL_W'(ALU_SUB);
          state_q <= S_BR_RES;
        end
        S_BR_RES: begin
          // ALU_Z reflects the compare issued by BR_CMP during this cycle.
          if ((ir_op(bus.IR) == OP_BEQ) ? bus.ALU_Z : !bus.ALU_Z) begin
            pc_rel_q <= 1'b1;
            pc_off_q <= bus.IR[3:0];
          end
          state_q <= S_FETCH;
        end
        S_NOOP:  state_q <= S_FETCH;
        S_HALT: begin
          halted_q <= 1'b1;
          if (bus.Run) state_q <= S_FETCH;
        end
        S_TRAP: begin
          halted_q  <= 1'b1;
          illegal_q <= 1'b1;
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign bus.PC_CLR    = pc_clr_q;
  assign bus.PC_IC     = pc_ic_q;
  assign bus.PC_LD     = pc_ld_q;
  assign bus.PC_REL    = pc_rel_q;
  assign bus.PC_D      = pc_d_q;
  assign bus.PC_OFF    = pc_off_q;
  assign bus.IR_LD     = ir_ld_q;
  assign bus.D_ADDR    = d_addr_q;
  assign bus.D_WR      = d_wr_q;
  assign bus.RF_S      = rf_s_q;
  assign bus.RF_W_EN   = rf_w_en_q;
  assign bus.RF_A_ADDR = rf_a_q;
  assign bus.RF_B_ADDR = rf_b_q;
  assign bus.RF_W_ADDR = rf_w_q;
  assign bus.ALU_S     = alu_s_q;
  assign bus.Halted    = halted_q;
  assign bus.Illegal   = illegal_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: per-instruction expected output sequences are
// queued by the driver and compared cycle by cycle by an independent monitor.
module tb_cpu_control_fsm;

  localparam int PC_W      = 8;
  localparam int LOAD_LAT  = 3;
  localparam int ALU_SEL_W = 4;

  typedef struct packed {
    logic       pc_clr, pc_ic, pc_ld, pc_rel;
    logic [7:0] pc_d;
    logic [3:0] pc_off;
    logic       ir_ld;
    logic [7:0] d_addr;
    logic       d_wr, rf_s, rf_w_en;
    logic [3:0] ra, rb, rw, alu_s;
    logic       halted, illegal;
  } outv_t;

  localparam int W = $bits(outv_t);

  logic Clock = 1'b0;
  logic Reset = 1'b0;

  cpu_control_fsm_if #(.PC_W(PC_W), .ALU_SEL_W(ALU_SEL_W)) bus ();

  cpu_control_fsm #(
    .PC_W(PC_W), .LOAD_LAT(LOAD_LAT), .ALU_SEL_W(ALU_SEL_W), .BR_EN(1)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  n_pop = 0;
  bit  mon_en = 1'b0;

  function automatic logic [W-1:0] sample_out();
    outv_t v;
    v = '0;
    v.pc_clr  = bus.PC_CLR;   v.pc_ic   = bus.PC_IC;
    v.pc_ld   = bus.PC_LD;    v.pc_rel  = bus.PC_REL;
    v.pc_d    = bus.PC_D;     v.pc_off  = bus.PC_OFF;
    v.ir_ld   = bus.IR_LD;    v.d_addr  = bus.D_ADDR;
    v.d_wr    = bus.D_WR;     v.rf_s    = bus.RF_S;
    v.rf_w_en = bus.RF_W_EN;  v.ra      = bus.RF_A_ADDR;
    v.rb      = bus.RF_B_ADDR; v.rw     = bus.RF_W_ADDR;
    v.alu_s   = bus.ALU_S;    v.halted  = bus.Halted;
    v.illegal = bus.Illegal;
    return v;
  endfunction

  always @(negedge Clock) begin
    if (mon_en) begin
      logic [W-1:0] got, exp_v;
      got = sample_out();
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL underflow: got %h with no expected entry", got);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          bad++;
          $display("FAIL out[%0d]: got %h expected %h (ir=%h)", n_pop, got, exp_v, bus.IR);
        end
      end
      n_pop++;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] alu_ref(input int op);
    case (op)
      3:  return 4'd1;
      4:  return 4'd2;
      6:  return 4'd3;
      7:  return 4'd4;
      8:  return 4'd5;
      9:  return 4'd7;
      10: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  task automatic push(input outv_t v);
    exp_q.push_back(v);
  endtask

  // Expected outputs, one entry per clock, from fetch to the last cycle of ir.
  task automatic model_instr(input logic [15:0] ir, input logic z, input int hn,
                             output int len);
    outv_t v;
    int op, start;
    logic taken;
    start = exp_q.size();
    op = int'(ir[15:12]);
    v = '0; v.ir_ld = 1'b1; push(v);
    v = '0; v.pc_ic = 1'b1; push(v);
    v = '0;
    case (op)
      0: push(v);
      1: begin v.d_addr = ir[7:0]; v.ra = ir[11:8]; v.d_wr = 1'b1; push(v); end
      2: for (int i = 0; i <= LOAD_LAT; i++) begin
           v = '0; v.d_addr = ir[11:4]; v.rf_s = 1'b1; v.rw = ir[3:0];
           v.rf_w_en = (i == LOAD_LAT);
           push(v);
         end
      5: begin v.halted = 1'b1; repeat (hn) push(v); end
      11: begin v.pc_ld = 1'b1; v.pc_d = ir[7:0]; push(v); end
      12, 13: begin
        v.ra = ir[11:8]; v.rb = ir[7:4]; v.alu_s = 4'd2; push(v);
        taken = (op == 12) ? z : !z;
        v = '0; v.pc_rel = taken; v.pc_off = taken ? ir[3:0] : 4'h0; push(v);
      end
      14, 15: begin v.halted = 1'b1; v.illegal = 1'b1; repeat (hn) push(v); end
      default: begin
        v.ra = ir[11:8]; v.rb = ir[7:4]; v.rw = ir[3:0];
        v.rf_w_en = 1'b1; v.alu_s = alu_ref(op); push(v);
      end
    endcase
    len = exp_q.size() - start;
  endtask

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic apply_reset(input int n);
    outv_t v;
    Reset = 1'b0;
    v = '0;
    repeat (n) push(v);
    repeat (n) @(posedge Clock);
    #1;
    total++;
    if (bus.state !== 5'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d expected 0", bus.state);
    end
    Reset = 1'b1;
    v = '0; v.pc_clr = 1'b1; push(v);
    @(posedge Clock);
    #1;
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic z, input int hn);
    int len;
    bus.IR = ir; bus.ALU_Z = z; bus.Run = 1'b0;
    model_instr(ir, z, hn, len);
    if (ir[15:12] == 4'h5) begin
      repeat (len - 1) @(posedge Clock);
      #1 bus.Run = 1'b1;
      @(posedge Clock);
      #1 bus.Run = 1'b0;
    end else begin
      for (int k = 0; k < len; k++) begin
        bus.Run = 1'($urandom_range(0, 1));
        @(posedge Clock);
        #1;
      end
      if (ir[15:13] == 3'b111) apply_reset($urandom_range(1, 2));
    end
  endtask

  // Reset lands while the load is still in its wait phase.
  task automatic load_abort(input logic [15:0] ir, input int k);
    outv_t v;
    bus.IR = ir; bus.Run = 1'b0;
    v = '0; v.ir_ld = 1'b1; push(v);
    v = '0; v.pc_ic = 1'b1; push(v);
    v = '0; v.d_addr = ir[11:4]; v.rf_s = 1'b1; v.rw = ir[3:0];
    repeat (1 + k) push(v);
    repeat (3 + k) @(posedge Clock);
    #1;
    apply_reset(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.IR = 16'h0000; bus.ALU_Z = 1'b0; bus.Run = 1'b0;
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    total++;
    if (sample_out() !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0", sample_out());
    end
    mon_en = 1'b1;
    push('0);
    apply_reset(2);

    run_instr(16'h3125, 1'b0, 1);
    run_instr(16'h4125, 1'b1, 1);
    run_instr(16'h2A73, 1'b0, 1);
    run_instr(16'hC12E, 1'b1, 1);
    run_instr(16'hC12E, 1'b0, 1);
    run_instr(16'hD12E, 1'b0, 1);
    run_instr(16'hB03C, 1'b0, 1);
    run_instr(16'h1A5C, 1'b0, 1);
    run_instr(16'h0FFF, 1'b1, 1);
    run_instr(16'h5000, 1'b0, 10);
    run_instr(16'hA9F0, 1'b0, 1);
    run_instr(16'hE000, 1'b0, 6);
    run_instr(16'hF123, 1'b1, 3);
    load_abort(16'h2A73, 0);
    load_abort(16'h2B14, 1);

    for (int i = 0; i < 120; i++) begin
      logic [15:0] ir;
      ir = 16'($urandom);
      if ($urandom_range(0, 9) == 0)
        load_abort({4'h2, ir[11:0]}, $urandom_range(0, 1));
      else
        run_instr(ir, 1'($urandom_range(0, 1)), $urandom_range(1, 4));
    end

    @(negedge Clock);
    #1;
    mon_en = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
